// File: rtl/ir_fetch_ctrl.sv
// Purpose: instruction-fetch sequencer; owns pc, reads icache over req/ack, buffers words+addresses for the decoder.
// Latency: ack in cycle N -> o_ir_valid in N+1 when the buffer was empty; head data/address come straight from registers.
// Backpressure: no new read is issued while the buffer would be full; a jump flushes the buffer and discards any in-flight read.
module ir_fetch_ctrl #(
    parameter int DATA_WIDTH    = 16,
    parameter int IR_ADDR_WIDTH = 10,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_cash_init_done,
    output logic                     o_mem_req,
    output logic [IR_ADDR_WIDTH-1:0] o_mem_addr,
    input  logic                     i_mem_ack,
    input  logic [DATA_WIDTH-1:0]    i_mem_data,
    input  logic                     i_jump_valid,
    input  logic [IR_ADDR_WIDTH-1:0] i_jump_addr,
    output logic                     o_ir_valid,
    output logic [DATA_WIDTH-1:0]    o_ir_data,
    output logic [IR_ADDR_WIDTH-1:0] o_irp,
    input  logic                     i_ir_ready,
    output logic                     o_busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_IDLE  = 2'd1,
        S_REQ   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t                   state;
    logic [IR_ADDR_WIDTH-1:0] pc;

    logic [DATA_WIDTH-1:0]    fifo_dat  [FIFO_DEPTH];
    logic [IR_ADDR_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic [CNT_W-1:0]         count;
    logic [CNT_W-1:0]         count_next;

    logic ack;
    logic jump;
    logic push;
    logic pop;
    logic room;

    // req/busy are decoded from the state register only, so they are glitch-free
    // and drop the moment the async reset forces INIT.
    assign o_mem_req  = (state == S_REQ) || (state == S_DRAIN);
    assign o_busy     = (state == S_INIT) || (state == S_DRAIN);

    // Ack only means something while a request is outstanding.
    assign ack        = o_mem_req & i_mem_ack;
    // Jumps are meaningless before the cache is up; they override push and pop.
    assign jump       = i_jump_valid & (state != S_INIT);
    assign push       = (state == S_REQ) & ack & ~i_jump_valid;

    assign o_ir_valid = (count != '0);
    assign pop        = o_ir_valid & i_ir_ready;
    assign count_next = count + CNT_W'(push) - CNT_W'(pop);
    assign room       = (count_next < CNT_W'(FIFO_DEPTH));

    assign o_ir_data  = fifo_dat[rd_ptr];
    assign o_irp      = fifo_addr[rd_ptr];

    // Fetch buffer: circular storage, flushed to empty by any accepted jump.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_dat[i]  <= '0;
                fifo_addr[i] <= '0;
            end
        end else if (jump) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_dat[wr_ptr]  <= i_mem_data;
                fifo_addr[wr_ptr] <= o_mem_addr;
                wr_ptr            <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_next;
        end
    end

    // Fetch sequencer: pc is the next address to request; o_mem_addr is held
    // unchanged for as long as a request is outstanding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_INIT;
            pc         <= '0;
            o_mem_addr <= '0;
        end else begin
            case (state)
                S_INIT: begin
                    if (i_cash_init_done) begin
                        state <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (jump) begin
                        pc         <= i_jump_addr;
                        o_mem_addr <= i_jump_addr;
                        state      <= S_REQ;
                    end else if (room) begin
                        o_mem_addr <= pc;
                        state      <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (jump) begin
                        pc <= i_jump_addr;
                        if (ack) begin
                            // Read finished this cycle; its word is dropped and the target can go out now.
                            o_mem_addr <= i_jump_addr;
                        end else begin
                            // A request is never withdrawn: wait out the stale read.
                            state <= S_DRAIN;
                        end
                    end else if (ack) begin
                        pc <= pc + IR_ADDR_WIDTH'(1);
                        if (room) begin
                            o_mem_addr <= pc + IR_ADDR_WIDTH'(1);
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_DRAIN: begin
                    if (jump) begin
                        pc <= i_jump_addr;
                    end
                    if (ack) begin
                        o_mem_addr <= jump ? i_jump_addr : pc;
                        state      <= S_REQ;
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_ir_fetch_ctrl.sv
// Purpose: directed self-checking bench for ir_fetch_ctrl with a wait-programmable icache responder.
// Latency: inputs driven and outputs observed on the falling edge, away from the active edge.
// Backpressure: decoder ready is driven directly by each scenario task.
module tb_ir_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        i_cash_init_done;
    logic        o_mem_req;
    logic [9:0]  o_mem_addr;
    logic        i_mem_ack;
    logic [15:0] i_mem_data;
    logic        i_jump_valid;
    logic [9:0]  i_jump_addr;
    logic        o_ir_valid;
    logic [15:0] o_ir_data;
    logic [9:0]  o_irp;
    logic        i_ir_ready;
    logic        o_busy;

    int tests;
    int fails;
    int ack_wait;
    int wcnt;
    int ack_cnt;

    ir_fetch_ctrl #(
        .DATA_WIDTH    (16),
        .IR_ADDR_WIDTH (10),
        .FIFO_DEPTH    (4)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_cash_init_done (i_cash_init_done),
        .o_mem_req        (o_mem_req),
        .o_mem_addr       (o_mem_addr),
        .i_mem_ack        (i_mem_ack),
        .i_mem_data       (i_mem_data),
        .i_jump_valid     (i_jump_valid),
        .i_jump_addr      (i_jump_addr),
        .o_ir_valid       (o_ir_valid),
        .o_ir_data        (o_ir_data),
        .o_irp            (o_irp),
        .i_ir_ready       (i_ir_ready),
        .o_busy           (o_busy)
    );

    // Instruction memory contents as a function of address.
    function automatic logic [15:0] dat_of(input logic [9:0] a);
        return {a[5:0], a} ^ 16'h5A3C;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Icache responder: acks after ack_wait idle cycles of an outstanding request.
    initial begin
        wcnt       = 0;
        i_mem_ack  = 1'b0;
        i_mem_data = '0;
        forever begin
            @(negedge clk);
            if (o_mem_req) begin
                if (wcnt >= ack_wait) begin
                    i_mem_ack  = 1'b1;
                    i_mem_data = dat_of(o_mem_addr);
                    wcnt       = 0;
                end else begin
                    i_mem_ack  = 1'b0;
                    wcnt       = wcnt + 1;
                end
            end else begin
                i_mem_ack = 1'b0;
                wcnt      = 0;
            end
        end
    end

    // Counts acks that should result in a buffered word.
    initial begin
        ack_cnt = 0;
        forever begin
            @(posedge clk);
            if (rst_n && o_mem_req && i_mem_ack && !i_jump_valid && !o_busy) ack_cnt = ack_cnt + 1;
        end
    end

    task automatic test_reset();
        repeat (2) @(negedge clk);
        tests++; if (o_mem_req !== 1'b0) begin fails++; $display("FAIL reset_req: got %b want 0", o_mem_req); end
        tests++; if (o_ir_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", o_ir_valid); end
        tests++; if (o_busy !== 1'b1) begin fails++; $display("FAIL reset_busy: got %b want 1", o_busy); end
        tests++; if (o_mem_addr !== 10'h000) begin fails++; $display("FAIL reset_addr: got %h want 000", o_mem_addr); end
        tests++; if (o_irp !== 10'h000 || o_ir_data !== 16'h0000) begin fails++; $display("FAIL reset_head: got %h/%h want 000/0000", o_irp, o_ir_data); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        tests++; if (o_mem_req !== 1'b0 || o_busy !== 1'b1) begin fails++; $display("FAIL init_wait: req %b busy %b want 0/1", o_mem_req, o_busy); end
    endtask

    task automatic test_stream();
        logic [9:0] e;
        i_ir_ready       = 1'b1;
        i_cash_init_done = 1'b1;
        @(negedge clk);
        tests++; if (o_mem_req !== 1'b0 || o_busy !== 1'b0) begin fails++; $display("FAIL idle_after_init: req %b busy %b want 0/0", o_mem_req, o_busy); end
        @(negedge clk);
        tests++; if (o_mem_req !== 1'b1 || o_mem_addr !== 10'h000) begin fails++; $display("FAIL first_req: req %b addr %h want 1/000", o_mem_req, o_mem_addr); end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            e = 10'(k);
            tests++;
            if (o_ir_valid !== 1'b1 || o_irp !== e || o_ir_data !== dat_of(e)) begin
                fails++; $display("FAIL stream_%0d: v %b irp %h dat %h want 1 %h %h", k, o_ir_valid, o_irp, o_ir_data, e, dat_of(e));
            end
        end
    endtask

    task automatic test_backpressure();
        int base;
        i_ir_ready   = 1'b0;
        i_jump_valid = 1'b1;
        i_jump_addr  = 10'h000;
        @(negedge clk);
        i_jump_valid = 1'b0;
        base = ack_cnt;
        repeat (8) @(negedge clk);
        tests++; if (ack_cnt - base !== 4) begin fails++; $display("FAIL fill_acks: got %0d want 4", ack_cnt - base); end
        tests++; if (o_mem_req !== 1'b0) begin fails++; $display("FAIL full_idle: req %b want 0", o_mem_req); end
        tests++; if (o_ir_valid !== 1'b1 || o_irp !== 10'h000 || o_ir_data !== dat_of(10'h000)) begin fails++; $display("FAIL full_head: v %b irp %h dat %h want 1 000 %h", o_ir_valid, o_irp, o_ir_data, dat_of(10'h000)); end
        i_ir_ready = 1'b1;
        @(negedge clk);
        i_ir_ready = 1'b0;
        tests++; if (o_mem_req !== 1'b1 || o_mem_addr !== 10'h004) begin fails++; $display("FAIL refill_req: req %b addr %h want 1/004", o_mem_req, o_mem_addr); end
        tests++; if (o_irp !== 10'h001) begin fails++; $display("FAIL refill_head: irp %h want 001", o_irp); end
        repeat (3) @(negedge clk);
        tests++; if (ack_cnt - base !== 5 || o_mem_req !== 1'b0) begin fails++; $display("FAIL refill_done: acks %0d req %b want 5/0", ack_cnt - base, o_mem_req); end
    endtask

    task automatic test_jump_wait();
        bit seen;
        ack_wait   = 3;
        i_ir_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (o_mem_req) seen = 1'b1;
        end
        tests++; if (!seen || o_mem_addr !== 10'h005) begin fails++; $display("FAIL wait_req_rise: seen %b addr %h want 1/005", seen, o_mem_addr); end
        @(negedge clk);
        i_jump_valid = 1'b1;
        i_jump_addr  = 10'h120;
        @(negedge clk);
        i_jump_valid = 1'b0;
        tests++; if (o_mem_req !== 1'b1 || o_mem_addr !== 10'h005 || o_busy !== 1'b1 || o_ir_valid !== 1'b0) begin
            fails++; $display("FAIL drain_hold: req %b addr %h busy %b v %b want 1 005 1 0", o_mem_req, o_mem_addr, o_busy, o_ir_valid);
        end
        @(negedge clk);
        tests++; if (o_mem_req !== 1'b1 || o_mem_addr !== 10'h005) begin fails++; $display("FAIL drain_hold2: req %b addr %h want 1/005", o_mem_req, o_mem_addr); end
        @(negedge clk);
        tests++; if (o_mem_req !== 1'b1 || o_mem_addr !== 10'h120 || o_busy !== 1'b0 || o_ir_valid !== 1'b0) begin
            fails++; $display("FAIL post_drain: req %b addr %h busy %b v %b want 1 120 0 0", o_mem_req, o_mem_addr, o_busy, o_ir_valid);
        end
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (o_ir_valid) seen = 1'b1;
        end
        tests++; if (!seen || o_irp !== 10'h120 || o_ir_data !== dat_of(10'h120)) begin
            fails++; $display("FAIL jump_first_word: seen %b irp %h dat %h want 1 120 %h", seen, o_irp, o_ir_data, dat_of(10'h120));
        end
    endtask

    task automatic test_jump_ack_pop();
        ack_wait = 0;
        repeat (4) @(negedge clk);
        tests++; if (o_ir_valid !== 1'b1 || o_mem_req !== 1'b1) begin fails++; $display("FAIL jap_pre: v %b req %b want 1/1", o_ir_valid, o_mem_req); end
        i_jump_valid = 1'b1;
        i_jump_addr  = 10'h200;
        @(negedge clk);
        i_jump_valid = 1'b0;
        tests++; if (o_ir_valid !== 1'b0 || o_mem_req !== 1'b1 || o_mem_addr !== 10'h200) begin
            fails++; $display("FAIL jap_flush: v %b req %b addr %h want 0 1 200", o_ir_valid, o_mem_req, o_mem_addr);
        end
        @(negedge clk);
        tests++; if (o_ir_valid !== 1'b1 || o_irp !== 10'h200 || o_ir_data !== dat_of(10'h200)) begin
            fails++; $display("FAIL jap_target: v %b irp %h dat %h want 1 200 %h", o_ir_valid, o_irp, o_ir_data, dat_of(10'h200));
        end
    endtask

    task automatic test_wrap();
        logic [9:0] e;
        i_jump_valid = 1'b1;
        i_jump_addr  = 10'h3FF;
        @(negedge clk);
        i_jump_valid = 1'b0;
        tests++; if (o_mem_req !== 1'b1 || o_mem_addr !== 10'h3FF) begin fails++; $display("FAIL wrap_req: req %b addr %h want 1/3ff", o_mem_req, o_mem_addr); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            e = 10'h3FF + 10'(k);
            tests++;
            if (o_ir_valid !== 1'b1 || o_irp !== e || o_ir_data !== dat_of(e)) begin
                fails++; $display("FAIL wrap_%0d: v %b irp %h dat %h want 1 %h %h", k, o_ir_valid, o_irp, o_ir_data, e, dat_of(e));
            end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        tests++; if (o_mem_req !== 1'b1) begin fails++; $display("FAIL ar_pre: req %b want 1", o_mem_req); end
        #2;
        rst_n            = 1'b0;
        i_cash_init_done = 1'b0;
        #1;
        tests++; if (o_mem_req !== 1'b0 || o_ir_valid !== 1'b0 || o_busy !== 1'b1) begin
            fails++; $display("FAIL ar_immediate: req %b v %b busy %b want 0 0 1", o_mem_req, o_ir_valid, o_busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            tests++; if (o_mem_req !== 1'b0 || o_busy !== 1'b1) begin fails++; $display("FAIL ar_hold_%0d: req %b busy %b want 0/1", k, o_mem_req, o_busy); end
        end
        i_cash_init_done = 1'b1;
        repeat (2) @(negedge clk);
        tests++; if (o_mem_req !== 1'b1 || o_mem_addr !== 10'h000) begin fails++; $display("FAIL ar_restart: req %b addr %h want 1/000", o_mem_req, o_mem_addr); end
    endtask

    initial begin
        tests            = 0;
        fails            = 0;
        ack_wait         = 0;
        rst_n            = 1'b0;
        i_cash_init_done = 1'b0;
        i_jump_valid     = 1'b0;
        i_jump_addr      = '0;
        i_ir_ready       = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_jump_wait();
        test_jump_ack_pop();
        test_wrap();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
